dispatch_router: RTL and testbench
==================================

# dispatch_router

Parametrised in-order dispatch stage between the dispatch queue and the typed reservation-station write ports of the scheduler. Each cycle it takes the longest dispatchable prefix of up to DISPATCH_WIDTH queue-head entries. It routes each accepted entry to a free write port of its functional-unit type and registers it for one cycle toward the RS. This generation generalises type count, ports per type and payload width. It adds serialising entries (PRIV/barrier), bubble-free port reuse and a saturating stall counter.

## Interface
- DISPATCH_WIDTH, 4, entries offered by the dispatch queue per cycle
- TYPE_NUM, 4, number of unit types (ALU/MDU/MEM/MISC)
- PORTS_PER_TYPE, 2, RS write ports per type; port index = type*PORTS_PER_TYPE + p
- DATA_WIDTH, 64, opaque entry payload width
- TYPE_WIDTH, 2, width of type field; codes >= TYPE_NUM are illegal
- STALL_CNT_WIDTH, 32, stall counter width
- clk  in  1  clock, all state on rising edge
- a_rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush
- dq_valid_i  in  DISPATCH_WIDTH  entry valid, slot 0 oldest
- dq_type_i  in  DISPATCH_WIDTH*TYPE_WIDTH  unit type per slot
- dq_serial_i  in  DISPATCH_WIDTH  entry must dispatch alone
- dq_data_i  in  DISPATCH_WIDTH*DATA_WIDTH  payload per slot
- dq_ready_o  out  DISPATCH_WIDTH  slot accepted this cycle (combinational)
- rs_valid_o  out  TYPE_NUM*PORTS_PER_TYPE  registered port valid
- rs_data_o  out  TYPE_NUM*PORTS_PER_TYPE*DATA_WIDTH  registered payload
- rs_ready_i  in  TYPE_NUM*PORTS_PER_TYPE  RS accepts port
- stall_cnt_o  out  STALL_CNT_WIDTH  saturating head-stall cycle count

## Operation
- Port j is free if ~rs_valid_o[j] | rs_ready_i[j]. Free ports of type t are ranked ascending by p.
- Slot i is accepted (dq_ready_o[i]=1) iff all of the following hold:
  - dq_valid_i[i] and ~flush_i.
  - All slots < i are accepted.
  - Type is legal.
  - The count of accepted slots < i of the same type is less than the count of free ports of that type.
  - Serialisation permits it.
- Serialisation rules:
  - A serial slot is accepted only at i=0, and only when every rs_valid_o bit is 0 or its ready is 1. That is, all output registers drain this cycle.
  - When slot 0 is serial, no slot > 0 is accepted.
  - A serial slot at i>0 blocks itself and all younger slots.
- Routing: the k-th accepted entry of type t (k from 0) goes to the k-th free port of type t.
- dq_ready_o is a contiguous prefix. Invalid slots stop the prefix.
- Illegal type: slot is never accepted and blocks younger slots. Upstream is responsible; the block must not hang the other outputs.
- Output register j on each edge:
  - If j received an entry, load payload and set valid.
  - Else if rs_ready_i[j], clear valid.
  - Else hold.
- Flush: all rs_valid_o clear on the next edge, rs_data_o hold, and nothing is accepted in the flush cycle.
- Stall counter increments by 1 on each edge where dq_valid_i[0]=1, ~flush_i and dq_ready_o[0]=0. It saturates at all-ones and is not cleared by flush.

## Timing
- Reset values:
  - rs_valid_o = 0
  - rs_data_o = 0
  - stall_cnt_o = 0
  - dq_ready_o follows inputs (0 with no valids)
- Latency: entry accepted at edge N is presented on rs_valid_o/rs_data_o from edge N.
- Throughput: a port held by valid & ready is reloaded in the same edge, giving one entry per port per cycle with no bubble.
- Handshake: rs_data_o stable while rs_valid_o & ~rs_ready_i.
- Simultaneous flush and rs_ready_i: flush wins and valid clears.
- Reset asserted mid-operation clears all state asynchronously. First acceptance is possible in the first cycle after deassertion.
- Combinational path: dq_*, rs_ready_i, rs_valid_o -> dq_ready_o. There is no combinational path to rs_valid_o.

## Test plan
- Mixed prefix, all ports empty, types [ALU,ALU,MEM,ALU]. Required response:
  - dq_ready_o=0111.
  - ALU ports 0/1 load slots 0/1, MEM port 0 loads slot 2.
  - stall_cnt_o unchanged.
- Back-pressure: ALU port 0 valid with ready=0, four ALU entries offered.
  - Only slot 0 is accepted, to ALU port 1.
  - Port 0 data holds for 3 cycles until ready.
- Serial entry:
  - Slot 0 serial with MISC port 0 valid and ready=0 gives dq_ready_o=0000 and stall_cnt_o increments.
  - Next cycle with ready=1, dq_ready_o=0001 and younger slots are blocked.
- Flush mid-stream: all 8 ports valid, flush_i=1 for one cycle.
  - All rs_valid_o are 0 after the edge.
  - dq_ready_o=0000 during flush.
  - stall_cnt_o is not incremented.
- Saturation: STALL_CNT_WIDTH=4, hold the head stalled for 20 cycles.
  - stall_cnt_o reaches 15 and stays.
  - Reset returns it to 0 asynchronously.
- Illegal type, TYPE_NUM=3: slot 1 type=3 gives dq_ready_o=0001 every cycle, with slots 2-3 never accepted.

Source files
------------

// File: rtl/dispatch_router_if.sv
// Dispatch-queue and reservation-station write-port bundle for dispatch_router.
// The router sits on the slave modport; the queue/RS environment uses master.
interface dispatch_router_if #(
   parameter int DISPATCH_WIDTH = 4,
   parameter int TYPE_NUM       = 4,
   parameter int PORTS_PER_TYPE = 2,
   parameter int DATA_WIDTH     = 64,
   parameter int TYPE_WIDTH     = 2
);
   localparam int NUM_PORTS = TYPE_NUM * PORTS_PER_TYPE;

   logic [DISPATCH_WIDTH-1:0]            dq_valid;
   logic [DISPATCH_WIDTH*TYPE_WIDTH-1:0] dq_type;
   logic [DISPATCH_WIDTH-1:0]            dq_serial;
   logic [DISPATCH_WIDTH*DATA_WIDTH-1:0] dq_data;
   logic [DISPATCH_WIDTH-1:0]            dq_ready;
   logic [NUM_PORTS-1:0]                 rs_valid;
   logic [NUM_PORTS*DATA_WIDTH-1:0]      rs_data;
   logic [NUM_PORTS-1:0]                 rs_ready;

   modport master (
      output dq_valid, dq_type, dq_serial, dq_data, rs_ready,
      input  dq_ready, rs_valid, rs_data
   );

   modport slave (
      input  dq_valid, dq_type, dq_serial, dq_data, rs_ready,
      output dq_ready, rs_valid, rs_data
   );
endinterface

// File: rtl/dispatch_router.sv
// In-order dispatch stage: accepts the longest dispatchable queue-head prefix and
// routes each entry to a free typed RS write port through a one-cycle register.
module dispatch_router #(
   parameter int DISPATCH_WIDTH  = 4,
   parameter int TYPE_NUM        = 4,
   parameter int PORTS_PER_TYPE  = 2,
   parameter int DATA_WIDTH      = 64,
   parameter int TYPE_WIDTH      = 2,
   parameter int STALL_CNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       a_rst_n,
   input  logic                       flush_i,
   dispatch_router_if.slave           bus,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);
   localparam int NUM_PORTS = TYPE_NUM * PORTS_PER_TYPE;

   logic [NUM_PORTS-1:0]                 rs_valid_q, rs_valid_d;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rs_data_q, rs_data_d;
   logic [STALL_CNT_WIDTH-1:0]           stall_q, stall_d;

   logic [NUM_PORTS-1:0]                 free;
   logic                                 all_drain;
   logic [NUM_PORTS-1:0]                 load_en;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] load_data;
   logic [DISPATCH_WIDTH-1:0]            ready;
   logic                                 blocked;
   logic                                 slot_ok;
   logic [TYPE_WIDTH-1:0]                slot_type;
   int                                   free_cnt [TYPE_NUM];
   int                                   acc_cnt  [TYPE_NUM];
   int                                   rank;

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      free      = ~rs_valid_q | bus.rs_ready;
      all_drain = &free;
      ready     = '0;
      load_en   = '0;
      load_data = '0;
      blocked   = flush_i;
      slot_ok   = 1'b0;
      slot_type = '0;
      rank      = 0;
      for (int t = 0; t < TYPE_NUM; t++) begin
         acc_cnt[t]  = 0;
         free_cnt[t] = 0;
         for (int p = 0; p < PORTS_PER_TYPE; p++) begin
            if (free[t*PORTS_PER_TYPE + p]) free_cnt[t] = free_cnt[t] + 1;
         end
      end

      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         slot_type = bus.dq_type[i*TYPE_WIDTH +: TYPE_WIDTH];
         slot_ok   = 1'b0;
         // A serial entry may only leave from the head once every port drains.
         if (!blocked && bus.dq_valid[i] && (!bus.dq_serial[i] || (i == 0 && all_drain))) begin
            for (int t = 0; t < TYPE_NUM; t++) begin
               if (slot_type == TYPE_WIDTH'(t) && acc_cnt[t] < free_cnt[t]) begin
                  slot_ok = 1'b1;
                  rank    = 0;
                  for (int p = 0; p < PORTS_PER_TYPE; p++) begin
                     if (free[t*PORTS_PER_TYPE + p]) begin
                        if (rank == acc_cnt[t]) begin
                           load_en[t*PORTS_PER_TYPE + p]   = 1'b1;
                           load_data[t*PORTS_PER_TYPE + p] = bus.dq_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        rank = rank + 1;
                     end
                  end
                  acc_cnt[t] = acc_cnt[t] + 1;
               end
            end
         end
         if (slot_ok) begin
            ready[i] = 1'b1;
            if (bus.dq_serial[i]) blocked = 1'b1;
         end else begin
            blocked = 1'b1;
         end
      end
   end

   always_comb begin
      rs_valid_d = rs_valid_q;
      rs_data_d  = rs_data_q;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (flush_i) begin
            rs_valid_d[j] = 1'b0;
         end else if (load_en[j]) begin
            rs_valid_d[j] = 1'b1;
            rs_data_d[j]  = load_data[j];
         end else if (bus.rs_ready[j]) begin
            rs_valid_d[j] = 1'b0;
         end
      end
      stall_d = stall_q;
      if (bus.dq_valid[0] && !flush_i && !ready[0] && stall_q != '1)
         stall_d = stall_q + STALL_CNT_WIDTH'(1);
   end

   // NOTE: state updates use non-blocking assignments so all registers sample
   // their next values from the same pre-edge snapshot.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         rs_valid_q <= '0;
         rs_data_q  <= '0;
         stall_q    <= '0;
      end else begin
         rs_valid_q <= rs_valid_d;
         rs_data_q  <= rs_data_d;
         stall_q    <= stall_d;
      end
   end

   assign bus.dq_ready = ready;
   assign bus.rs_valid = rs_valid_q;
   assign bus.rs_data  = rs_data_q;
   assign stall_cnt_o  = stall_q;
endmodule

// File: tb/tb_dispatch_router.sv
// Directed bench for dispatch_router: main instance plus a 4-bit stall counter
// instance and a three-type instance for the illegal-type case.
module tb_dispatch_router;
   logic        clk = 1'b0;
   logic        a_rst_n = 1'b1;
   logic        flush_m = 1'b0, flush_s = 1'b0, flush_x = 1'b0;
   logic [31:0] stall_m;
   logic [3:0]  stall_s;
   logic [31:0] stall_x;
   int          errors = 0;
   int          checks = 0;

   dispatch_router_if #(.DISPATCH_WIDTH(4), .TYPE_NUM(4), .PORTS_PER_TYPE(2),
                        .DATA_WIDTH(64), .TYPE_WIDTH(2)) m_if ();
   dispatch_router_if #(.DISPATCH_WIDTH(4), .TYPE_NUM(4), .PORTS_PER_TYPE(2),
                        .DATA_WIDTH(64), .TYPE_WIDTH(2)) s_if ();
   dispatch_router_if #(.DISPATCH_WIDTH(4), .TYPE_NUM(3), .PORTS_PER_TYPE(2),
                        .DATA_WIDTH(64), .TYPE_WIDTH(2)) x_if ();

   dispatch_router #(.DISPATCH_WIDTH(4), .TYPE_NUM(4), .PORTS_PER_TYPE(2), .DATA_WIDTH(64),
                     .TYPE_WIDTH(2), .STALL_CNT_WIDTH(32)) u_main (
      .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush_m), .bus(m_if), .stall_cnt_o(stall_m));
   dispatch_router #(.DISPATCH_WIDTH(4), .TYPE_NUM(4), .PORTS_PER_TYPE(2), .DATA_WIDTH(64),
                     .TYPE_WIDTH(2), .STALL_CNT_WIDTH(4)) u_sat (
      .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush_s), .bus(s_if), .stall_cnt_o(stall_s));
   dispatch_router #(.DISPATCH_WIDTH(4), .TYPE_NUM(3), .PORTS_PER_TYPE(2), .DATA_WIDTH(64),
                     .TYPE_WIDTH(2), .STALL_CNT_WIDTH(32)) u_ill (
      .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush_x), .bus(x_if), .stall_cnt_o(stall_x));

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 a_rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (m_if.rs_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h want 00", m_if.rs_valid); end
      checks++; if (m_if.rs_data !== '0) begin errors++; $display("FAIL reset_data: got nonzero payload"); end
      checks++; if (stall_m !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_m); end
      checks++; if (m_if.dq_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", m_if.dq_ready); end
      a_rst_n = 1'b1;
      m_if.dq_valid = 4'b0001;
      m_if.dq_type  = '0;
      m_if.dq_data  = {64'h0, 64'h0, 64'h0, 64'hA0};
      #1;
      checks++; if (m_if.dq_ready !== 4'b0001) begin errors++; $display("FAIL first_accept_ready: got %b want 0001", m_if.dq_ready); end
      step();
      checks++; if (m_if.rs_valid !== 8'h01 || m_if.rs_data[63:0] !== 64'hA0) begin
         errors++; $display("FAIL first_accept_load: valid %h data %h want 01/a0", m_if.rs_valid, m_if.rs_data[63:0]); end
      m_if.dq_valid = '0;
      m_if.rs_ready = 8'hFF;
      step();
      checks++; if (m_if.rs_valid !== 8'h00) begin errors++; $display("FAIL drain: got %h want 00", m_if.rs_valid); end
      m_if.rs_ready = 8'h00;
   endtask

   task automatic test_mixed_prefix();
      m_if.dq_valid = 4'b1111;
      m_if.dq_type  = {2'd0, 2'd2, 2'd0, 2'd0};
      m_if.dq_data  = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
      #1;
      checks++; if (m_if.dq_ready !== 4'b0111) begin errors++; $display("FAIL mixed_ready: got %b want 0111", m_if.dq_ready); end
      step();
      checks++; if (m_if.rs_valid !== 8'b0001_0011) begin errors++; $display("FAIL mixed_valid: got %b want 00010011", m_if.rs_valid); end
      checks++; if (m_if.rs_data[0*64 +: 64] !== 64'hD0 || m_if.rs_data[1*64 +: 64] !== 64'hD1 || m_if.rs_data[4*64 +: 64] !== 64'hD2) begin
         errors++; $display("FAIL mixed_data: p0 %h p1 %h p4 %h want d0/d1/d2",
                            m_if.rs_data[0*64 +: 64], m_if.rs_data[1*64 +: 64], m_if.rs_data[4*64 +: 64]); end
      checks++; if (stall_m !== 32'd0) begin errors++; $display("FAIL mixed_stall: got %0d want 0", stall_m); end
   endtask

   task automatic test_back_to_back();
      m_if.rs_ready = 8'hFF;
      m_if.dq_valid = 4'b0011;
      m_if.dq_type  = '0;
      m_if.dq_data  = {64'h0, 64'h0, 64'hB1, 64'hB0};
      #1;
      checks++; if (m_if.dq_ready !== 4'b0011) begin errors++; $display("FAIL b2b_ready: got %b want 0011", m_if.dq_ready); end
      step();
      checks++; if (m_if.rs_valid !== 8'h03) begin errors++; $display("FAIL b2b_valid: got %h want 03", m_if.rs_valid); end
      checks++; if (m_if.rs_data[0*64 +: 64] !== 64'hB0 || m_if.rs_data[1*64 +: 64] !== 64'hB1) begin
         errors++; $display("FAIL b2b_data: p0 %h p1 %h want b0/b1", m_if.rs_data[0*64 +: 64], m_if.rs_data[1*64 +: 64]); end
   endtask

   task automatic test_back_pressure();
      m_if.rs_ready = 8'h02;
      m_if.dq_valid = 4'b1111;
      m_if.dq_type  = '0;
      m_if.dq_data  = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
      #1;
      checks++; if (m_if.dq_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready: got %b want 0001", m_if.dq_ready); end
      step();
      checks++; if (m_if.rs_valid !== 8'h03 || m_if.rs_data[1*64 +: 64] !== 64'hC0) begin
         errors++; $display("FAIL bp_route: valid %h p1 %h want 03/c0", m_if.rs_valid, m_if.rs_data[1*64 +: 64]); end
      m_if.dq_valid = '0;
      m_if.rs_ready = 8'h00;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (m_if.rs_valid[0] !== 1'b1 || m_if.rs_data[0*64 +: 64] !== 64'hB0) begin
            errors++; $display("FAIL bp_hold%0d: valid %b data %h want 1/b0", c, m_if.rs_valid[0], m_if.rs_data[0*64 +: 64]); end
      end
      m_if.rs_ready = 8'hFF;
      step();
      checks++; if (m_if.rs_valid !== 8'h00) begin errors++; $display("FAIL bp_release: got %h want 00", m_if.rs_valid); end
      checks++; if (stall_m !== 32'd0) begin errors++; $display("FAIL bp_stall: got %0d want 0", stall_m); end
   endtask

   task automatic test_serial();
      m_if.rs_ready  = 8'h00;
      m_if.dq_valid  = 4'b0001;
      m_if.dq_type   = {2'd0, 2'd0, 2'd0, 2'd3};
      m_if.dq_serial = 4'b0000;
      m_if.dq_data   = {64'h0, 64'h0, 64'h0, 64'hE0};
      step();
      checks++; if (m_if.rs_valid !== 8'h40) begin errors++; $display("FAIL serial_setup: got %h want 40", m_if.rs_valid); end
      m_if.dq_valid  = 4'b1111;
      m_if.dq_serial = 4'b0001;
      m_if.dq_data   = {64'hE3, 64'hE2, 64'hE1, 64'h5E0};
      #1;
      checks++; if (m_if.dq_ready !== 4'b0000) begin errors++; $display("FAIL serial_wait_ready: got %b want 0000", m_if.dq_ready); end
      step();
      checks++; if (stall_m !== 32'd1) begin errors++; $display("FAIL serial_stall: got %0d want 1", stall_m); end
      m_if.rs_ready = 8'h40;
      #1;
      checks++; if (m_if.dq_ready !== 4'b0001) begin errors++; $display("FAIL serial_go_ready: got %b want 0001", m_if.dq_ready); end
      step();
      checks++; if (m_if.rs_valid !== 8'h40 || m_if.rs_data[6*64 +: 64] !== 64'h5E0 || stall_m !== 32'd1) begin
         errors++; $display("FAIL serial_go_load: valid %h p6 %h stall %0d want 40/5e0/1",
                            m_if.rs_valid, m_if.rs_data[6*64 +: 64], stall_m); end
      m_if.rs_ready  = 8'hFF;
      m_if.dq_valid  = 4'b0111;
      m_if.dq_type   = {2'd0, 2'd0, 2'd3, 2'd0};
      m_if.dq_serial = 4'b0010;
      m_if.dq_data   = {64'h0, 64'hF2, 64'hF1, 64'hF0};
      #1;
      checks++; if (m_if.dq_ready !== 4'b0001) begin errors++; $display("FAIL serial_young_ready: got %b want 0001", m_if.dq_ready); end
      step();
      checks++; if (m_if.rs_valid !== 8'h01 || m_if.rs_data[0*64 +: 64] !== 64'hF0 || stall_m !== 32'd1) begin
         errors++; $display("FAIL serial_young_load: valid %h p0 %h stall %0d want 01/f0/1",
                            m_if.rs_valid, m_if.rs_data[0*64 +: 64], stall_m); end
      m_if.dq_valid  = '0;
      m_if.dq_serial = '0;
      step();
      m_if.rs_ready = 8'h00;
   endtask

   task automatic test_flush();
      m_if.dq_valid = 4'b1111;
      m_if.dq_type  = {2'd1, 2'd1, 2'd0, 2'd0};
      m_if.dq_data  = {64'hF003, 64'hF002, 64'hF001, 64'hF000};
      step();
      m_if.dq_type  = {2'd3, 2'd3, 2'd2, 2'd2};
      m_if.dq_data  = {64'hF007, 64'hF006, 64'hF005, 64'hF004};
      #1;
      checks++; if (m_if.dq_ready !== 4'b1111) begin errors++; $display("FAIL fill_ready: got %b want 1111", m_if.dq_ready); end
      step();
      checks++; if (m_if.rs_valid !== 8'hFF) begin errors++; $display("FAIL fill_valid: got %h want ff", m_if.rs_valid); end
      flush_m       = 1'b1;
      m_if.rs_ready = 8'h0F;
      m_if.dq_type  = '0;
      m_if.dq_data  = {64'h11, 64'h22, 64'h33, 64'h44};
      #1;
      checks++; if (m_if.dq_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b want 0000", m_if.dq_ready); end
      step();
      checks++; if (m_if.rs_valid !== 8'h00) begin errors++; $display("FAIL flush_valid: got %h want 00", m_if.rs_valid); end
      checks++; if (m_if.rs_data[0*64 +: 64] !== 64'hF000 || m_if.rs_data[7*64 +: 64] !== 64'hF007) begin
         errors++; $display("FAIL flush_data_hold: p0 %h p7 %h want f000/f007", m_if.rs_data[0*64 +: 64], m_if.rs_data[7*64 +: 64]); end
      checks++; if (stall_m !== 32'd1) begin errors++; $display("FAIL flush_stall: got %0d want 1", stall_m); end
      flush_m       = 1'b0;
      m_if.dq_valid = '0;
      m_if.rs_ready = 8'h00;
   endtask

   task automatic test_saturation();
      s_if.rs_ready = 8'h00;
      s_if.dq_valid = 4'b0011;
      s_if.dq_type  = '0;
      s_if.dq_data  = {64'h0, 64'h0, 64'h71, 64'h70};
      step();
      s_if.dq_valid = 4'b0001;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 5) begin
            checks++; if (stall_s !== 4'd5) begin errors++; $display("FAIL sat_count5: got %0d want 5", stall_s); end
         end
      end
      checks++; if (stall_s !== 4'd15) begin errors++; $display("FAIL sat_count20: got %0d want 15", stall_s); end
      step();
      checks++; if (stall_s !== 4'd15 || s_if.dq_ready !== 4'b0000) begin
         errors++; $display("FAIL sat_hold: stall %0d ready %b want 15/0000", stall_s, s_if.dq_ready); end
      #2 a_rst_n = 1'b0;
      #1;
      checks++; if (stall_s !== 4'd0 || s_if.rs_valid !== 8'h00) begin
         errors++; $display("FAIL sat_async_reset: stall %0d valid %h want 0/00", stall_s, s_if.rs_valid); end
      s_if.dq_valid = '0;
      @(negedge clk);
      a_rst_n = 1'b1;
   endtask

   task automatic test_illegal_type();
      x_if.rs_ready  = 6'h3F;
      x_if.dq_valid  = 4'b1111;
      x_if.dq_type   = {2'd1, 2'd0, 2'd3, 2'd0};
      x_if.dq_serial = '0;
      x_if.dq_data   = {64'h93, 64'h92, 64'h91, 64'h90};
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (x_if.dq_ready !== 4'b0001) begin errors++; $display("FAIL illegal_ready%0d: got %b want 0001", c, x_if.dq_ready); end
         step();
         checks++; if (x_if.rs_valid !== 6'h01 || x_if.rs_data[63:0] !== 64'h90 || stall_x !== 32'd0) begin
            errors++; $display("FAIL illegal_out%0d: valid %h p0 %h stall %0d want 01/90/0",
                               c, x_if.rs_valid, x_if.rs_data[63:0], stall_x); end
      end
      x_if.dq_valid = '0;
   endtask

   initial begin
      m_if.dq_valid = '0; m_if.dq_type = '0; m_if.dq_serial = '0; m_if.dq_data = '0; m_if.rs_ready = '0;
      s_if.dq_valid = '0; s_if.dq_type = '0; s_if.dq_serial = '0; s_if.dq_data = '0; s_if.rs_ready = '0;
      x_if.dq_valid = '0; x_if.dq_type = '0; x_if.dq_serial = '0; x_if.dq_data = '0; x_if.rs_ready = '0;
      test_reset();
      test_mixed_prefix();
      test_back_to_back();
      test_back_pressure();
      test_serial();
      test_flush();
      test_saturation();
      test_illegal_type();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
